// File: rtl/proc_pkg.sv
// Shared definitions for the vector-processor pipeline control blocks.
package proc_pkg;

   localparam int REG_AW  = 3;
   localparam int INSTR_W = 14;

   localparam logic [3:0] NOP_OPC = 4'b0000;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/scoreboard_bank.sv
// Per-register pending-write counters for one register file.
// Busy means a write is still in flight; rd_busy flags a source that must wait.
module scoreboard_bank
   import proc_pkg::*;
#(
   parameter int NREG   = 8,
   parameter int WB_LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic [REG_AW-1:0] load_addr,
   input  logic [REG_AW-1:0] rd_addr_a,
   input  logic [REG_AW-1:0] rd_addr_b,
   output logic [NREG-1:0]   busy,
   output logic              rd_busy
);

   localparam int CW = $clog2(WB_LAT + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(WB_LAT);
   localparam logic [CW-1:0] WB_CNT   = CW'(1);

   logic [CW-1:0] cnt_q [NREG];

   // NOTE: this is a small flop array, not a RAM, so every entry is reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (load_en && load_addr == REG_AW'(i))
               cnt_q[i] <= LOAD_VAL;
            else if (cnt_q[i] != '0)
               cnt_q[i] <= cnt_q[i] - 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) busy[i] = (cnt_q[i] != '0);
   end

   // In the WB cycle (count 1) the written value is forwarded, so it no longer blocks.
   assign rd_busy = (cnt_q[rd_addr_a] > WB_CNT) | (cnt_q[rd_addr_b] > WB_CNT);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stall detection at ID and branch flush of IF/ID.
module pipe_hazard_ctrl
   import proc_pkg::*;
#(
   parameter int NREG      = 8,
   parameter int WB_LAT    = 3,
   parameter int FLUSH_CYC = 1,
   parameter int PERF_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic              id_rdv,
   input  logic              id_rds,
   input  logic [REG_AW-1:0] id_src1,
   input  logic [REG_AW-1:0] id_src2,
   input  logic [REG_AW-1:0] id_ssrc,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_wrv,
   input  logic              id_wrs,
   input  logic              ex_br_taken,
   output logic              pc_hold,
   output logic              ifid_hold,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic [NREG-1:0]   busy_v,
   output logic [NREG-1:0]   busy_s,
   output logic [1:0]        ctrl_state,
   output logic [PERF_W-1:0] stall_cnt
);

   logic              blk_v, blk_s;
   logic              br, hazard, flush_now, issue;
   logic [2:0]        flush_cnt_q, flush_cnt_d;
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
   ctrl_state_e       state_q, state_d;

   scoreboard_bank #(.NREG(NREG), .WB_LAT(WB_LAT)) u_sb_vec (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (issue & id_wrv),
      .load_addr (id_dest),
      .rd_addr_a (id_src1),
      .rd_addr_b (id_src2),
      .busy      (busy_v),
      .rd_busy   (blk_v)
   );

   scoreboard_bank #(.NREG(NREG), .WB_LAT(WB_LAT)) u_sb_scl (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (issue & id_wrs),
      .load_addr (id_dest),
      .rd_addr_a (id_ssrc),
      .rd_addr_b (id_ssrc),
      .busy      (busy_s),
      .rd_busy   (blk_s)
   );

   // Gating with rst_n keeps every control output low while reset is asserted.
   assign br        = ex_br_taken & rst_n;
   assign hazard    = rst_n & id_valid & ((id_rdv & blk_v) | (id_rds & blk_s));
   assign flush_now = br | (flush_cnt_q != 3'd0);
   assign issue     = id_valid & ~hazard & ~flush_now;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      state_d     = ST_RUN;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
      if (flush_now) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         state_d     = ST_FLUSH;
         if (br) flush_cnt_d = 3'(FLUSH_CYC - 1);
      end else if (hazard) begin
         pc_hold     = 1'b1;
         ifid_hold   = 1'b1;
         idex_bubble = 1'b1;
         state_d     = ST_STALL;
         if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt_q <= 3'd0;
         stall_cnt_q <= '0;
         state_q     <= ST_RUN;
      end else begin
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         state_q     <= state_d;
      end
   end

   assign ctrl_state = state_q;
   assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: instance a uses defaults, instance b uses FLUSH_CYC=2 and PERF_W=2.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid, id_rdv, id_rds, id_wrv, id_wrs, ex_br_taken;
   logic [2:0] id_src1, id_src2, id_ssrc, id_dest;

   logic       a_ph, a_ih, a_fl, a_bb, b_ph, b_ih, b_fl, b_bb;
   logic [7:0] a_bv, a_bs, b_bv, b_bs;
   logic [1:0] a_st, b_st;
   logic [15:0] a_sc;
   logic [1:0]  b_sc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl u_a (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rdv(id_rdv), .id_rds(id_rds),
      .id_src1(id_src1), .id_src2(id_src2), .id_ssrc(id_ssrc), .id_dest(id_dest),
      .id_wrv(id_wrv), .id_wrs(id_wrs), .ex_br_taken(ex_br_taken),
      .pc_hold(a_ph), .ifid_hold(a_ih), .ifid_flush(a_fl), .idex_bubble(a_bb),
      .busy_v(a_bv), .busy_s(a_bs), .ctrl_state(a_st), .stall_cnt(a_sc)
   );

   pipe_hazard_ctrl #(.FLUSH_CYC(2), .PERF_W(2)) u_b (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rdv(id_rdv), .id_rds(id_rds),
      .id_src1(id_src1), .id_src2(id_src2), .id_ssrc(id_ssrc), .id_dest(id_dest),
      .id_wrv(id_wrv), .id_wrs(id_wrs), .ex_br_taken(ex_br_taken),
      .pc_hold(b_ph), .ifid_hold(b_ih), .ifid_flush(b_fl), .idex_bubble(b_bb),
      .busy_v(b_bv), .busy_s(b_bs), .ctrl_state(b_st), .stall_cnt(b_sc)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Control outputs packed as {pc_hold, ifid_hold, ifid_flush, idex_bubble}.
   task automatic chk_a(input string tag, input logic [3:0] exp);
      check({tag, " a_ctl"}, {28'd0, a_ph, a_ih, a_fl, a_bb}, {28'd0, exp});
   endtask

   task automatic chk_b(input string tag, input logic [3:0] exp);
      check({tag, " b_ctl"}, {28'd0, b_ph, b_ih, b_fl, b_bb}, {28'd0, exp});
   endtask

   task automatic drv(input logic v, input logic rdv, input logic rds, input logic [2:0] s1,
                      input logic [2:0] s2, input logic [2:0] ss, input logic [2:0] d,
                      input logic wv, input logic ws, input logic br);
      id_valid = v;  id_rdv = rdv; id_rds = rds;
      id_src1 = s1;  id_src2 = s2; id_ssrc = ss; id_dest = d;
      id_wrv = wv;   id_wrs = ws;  ex_br_taken = br;
   endtask

   task automatic idle();           drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic wr_v(input logic [2:0] r); drv(1, 0, 0, 0, 0, 0, r, 1, 0, 0); endtask
   task automatic wr_s(input logic [2:0] r); drv(1, 0, 0, 0, 0, 0, r, 0, 1, 0); endtask
   task automatic rd_v(input logic [2:0] r); drv(1, 1, 0, r, 0, 0, 0, 0, 0, 0); endtask
   task automatic rd_s(input logic [2:0] r); drv(1, 0, 1, 0, 0, r, 0, 0, 0, 0); endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst state", a_st, 0);
      check("rst busy_v", a_bv, 0);
      check("rst stall_cnt", a_sc, 0);
      chk_a("rst", 4'b0000);
      tick();

      // Vector RAW: producer in cycle 0, consumer stalls cycles 1-2, issues in 3
      wr_v(2);
      @(negedge clk); chk_a("raw c0", 4'b0000); check("raw c0 busy_v", a_bv, 0);
      tick();
      rd_v(2);
      @(negedge clk); chk_a("raw c1", 4'b1101); check("raw c1 busy_v", a_bv, 8'h04);
      check("raw c1 state", a_st, 0);
      tick();
      @(negedge clk); chk_a("raw c2", 4'b1101); check("raw c2 state", a_st, 1);
      check("raw c2 stall_cnt", a_sc, 1);
      tick();
      @(negedge clk); chk_a("raw c3", 4'b0000); check("raw c3 state", a_st, 1);
      check("raw c3 stall_cnt", a_sc, 2);
      tick();
      idle();
      @(negedge clk); check("raw c4 state", a_st, 0); check("raw c4 stall_cnt", a_sc, 2);
      tick();

      // File separation: a scalar write never blocks a vector read
      wr_s(2);
      tick();
      rd_v(2);
      @(negedge clk); chk_a("sep vread", 4'b0000); check("sep busy_s", a_bs, 8'h04);
      check("sep busy_v", a_bv, 0);
      tick();
      idle();
      repeat (3) tick();
      wr_s(2);
      tick();
      rd_s(2);
      @(negedge clk); chk_a("sep s1", 4'b1101);
      tick();
      @(negedge clk); chk_a("sep s2", 4'b1101);
      tick();
      @(negedge clk); chk_a("sep s3", 4'b0000); check("sep stall_cnt", a_sc, 4);
      tick();

      // WAW reload keeps busy_v[4] high for 4 cycles
      do_reset();
      wr_v(4);
      @(negedge clk); check("waw c0", a_bv[4], 0);
      tick();
      wr_v(4);
      @(negedge clk); check("waw c1", a_bv[4], 1);
      tick();
      idle();
      for (int c = 2; c <= 5; c++) begin
         @(negedge clk);
         check($sformatf("waw c%0d", c), a_bv[4], (c <= 4) ? 1 : 0);
         tick();
      end

      // Branch over an active hazard: b flushes 2 cycles, a flushes 1 then stalls
      do_reset();
      wr_v(1);
      tick();
      drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 1);
      @(negedge clk); chk_a("br c1", 4'b0011); chk_b("br c1", 4'b0011);
      tick();
      rd_v(1);
      @(negedge clk); chk_a("br c2", 4'b1101); chk_b("br c2", 4'b0011);
      check("br c2 a_state", a_st, 2); check("br c2 b_state", b_st, 2);
      check("br c2 b_stall", b_sc, 0);
      tick();
      @(negedge clk); chk_a("br c3", 4'b0000); chk_b("br c3", 4'b0000);
      check("br c3 a_state", a_st, 1); check("br c3 b_state", b_st, 2);
      check("br c3 a_stall", a_sc, 1); check("br c3 b_stall", b_sc, 0);
      tick();
      idle();
      @(negedge clk); check("br c4 b_state", b_st, 0);
      tick();

      // Saturation: three RAW pairs give 6 stall cycles; 2-bit counter stops at 3
      for (int k = 0; k < 3; k++) begin
         wr_v(3'(3 + k));
         tick();
         rd_v(3'(3 + k));
         repeat (3) tick();
         idle();
         @(negedge clk);
         check($sformatf("sat b_stall %0d", k), b_sc, (k == 0) ? 2 : 3);
         tick();
      end
      check("sat a_stall", a_sc, 7);

      // Reset in the middle of a stall
      wr_v(5);
      tick();
      drv(1, 1, 0, 0, 5, 0, 0, 0, 0, 0);
      @(negedge clk); chk_a("mid c1", 4'b1101);
      tick();
      @(negedge clk); check("mid c2 state", a_st, 1);
      rst_n = 1'b0;
      ex_br_taken = 1'b1;
      #1;
      check("mid rst busy_v", a_bv, 0);
      check("mid rst stall_cnt", a_sc, 0);
      check("mid rst state", a_st, 0);
      chk_a("mid rst", 4'b0000);
      chk_b("mid rst", 4'b0000);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle();
      @(negedge clk); check("mid rel state", a_st, 0); chk_a("mid rel", 4'b0000);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
